xor_puf_eval_ctrl: RTL and testbench
====================================

Name: xor_puf_eval_ctrl

Overview:
- Sequencer for the 128-bit XOR PUF macro.
- Runs NUM_EVAL reset/settle/excite/sample evaluations, synchronises the asynchronous PUF outputs, and accumulates a per-bit count of ones.
- Resolves a majority-voted response and counts unstable bits.
- Sits between the SPI register bank (START/ABORT in, RESP/status out) and the PUF macro pins I1_XOR, I2_XOR and RESET_XOR.

Parameters:
- N_BITS, 128: PUF width.
- NUM_EVAL, 7: evaluations per response; must be odd, range 1..15.
- RST_CYC, 4: cycles RESET_XOR is held low per evaluation; range 1..255.
- SETTLE_CYC, 4: cycles after reset release before excitation; range 1..255.
- EVAL_CYC, 8: cycles I1/I2 are held high before sampling; range 1..255.

Ports:
- CLK  in  1  system clock.
- RN  in  1  asynchronous active-low reset.
- START  in  1  single-cycle request; honoured only in IDLE.
- ABORT  in  1  cancels the current run.
- PUF_OUT_XOR  in  N_BITS  raw PUF outputs, asynchronous to CLK.
- I1_XOR  out  1  PUF excitation input 1.
- I2_XOR  out  1  PUF excitation input 2.
- RESET_XOR  out  1  PUF reset, active low.
- RESP  out  N_BITS  majority-voted response.
- UNSTABLE_CNT  out  8  number of bits whose count is neither 0 nor NUM_EVAL.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse when RESP is updated.
- VALID  out  1  RESP/UNSTABLE_CNT hold a complete result.

Behaviour:
- Reset values, asynchronous: I1_XOR=0, I2_XOR=0, RESET_XOR=0 (PUF held in reset), RESP=0, UNSTABLE_CNT=0, BUSY=0, DONE=0, VALID=0, all counters 0, state IDLE. All outputs are registered.
- States:
  - IDLE
  - RST
  - SETTLE
  - EXCITE
  - SAMPLE
  - ACCUM
  - RESOLVE
  - FIN
- IDLE: RESET_XOR=0, I1=I2=0. START=1 and ABORT=0 → RST. On that edge: BUSY←1, VALID←0, eval index←0, all per-bit counters cnt[i] (4 bits) ←0.
- RST: RESET_XOR=0 for RST_CYC cycles → SETTLE.
- SETTLE: RESET_XOR=1, I1=I2=0 for SETTLE_CYC cycles → EXCITE.
- EXCITE: I1_XOR and I2_XOR both high, switched on the same edge, for EVAL_CYC cycles → SAMPLE.
- SAMPLE (2 cycles): I1/I2 stay high, RESET_XOR stays 1. PUF_OUT_XOR passes through a 2-flop synchroniser that is clocked every cycle → ACCUM.
- ACCUM (1 cycle):
  - cnt[i] += sync[i] for all i.
  - eval index++.
  - I1=I2=0, RESET_XOR=0.
  - If index reaches NUM_EVAL → RESOLVE; else → RST.
- RESOLVE (N_BITS cycles, bit j on cycle j, j=0 first):
  - RESP[j] ← (cnt[j] > NUM_EVAL/2, integer division).
  - If 0 < cnt[j] < NUM_EVAL, UNSTABLE_CNT increments; it saturates at 255 and is cleared on the entry edge into RESOLVE.
  - PUF pins are at idle values.
  - After bit N_BITS-1 → FIN.
- FIN (1 cycle): DONE=1, VALID←1, BUSY←0 → IDLE.
- Latency: DONE is high exactly 1 + NUM_EVAL·(RST_CYC+SETTLE_CYC+EVAL_CYC+3) + N_BITS cycles after the edge that samples START. With defaults this is 262.
- START while BUSY is ignored; no queueing.
- ABORT=1 in any non-IDLE state → IDLE on the next edge:
  - PUF pins go to idle values and BUSY←0.
  - No DONE pulse; VALID stays 0.
  - RESP and UNSTABLE_CNT keep whatever partial values they hold, but are meaningless while VALID=0.
- ABORT and START in the same IDLE cycle: ABORT wins and the request is dropped.
- RN low at any point: immediate return to the reset values; the next run requires a fresh START.
- RESP and UNSTABLE_CNT are stable from FIN until the next accepted START.
- cnt width is 4 bits; with NUM_EVAL ≤ 15 it cannot overflow.

Test Plan:
- Defaults, PUF model drives constant 0xA5A5...A5. START pulse →
  - BUSY=1 the next cycle.
  - Per evaluation: RESET_XOR low 4 cycles, settle 4 cycles, I1/I2 high 10 cycles; 7 evaluations.
  - DONE pulse at cycle 262, RESP=0xA5A5...A5, UNSTABLE_CNT=0, VALID=1.
- PUF model flips bit 0 high in evaluations 0,2,4 only (3/7) and bit 127 high in evaluations 0–3 (4/7) → RESP[0]=0, RESP[127]=1, UNSTABLE_CNT=2.
- ABORT asserted during the 3rd EXCITE → next cycle state IDLE, BUSY=0, RESET_XOR=0, I1=I2=0, no DONE, VALID=0. A following START runs a full 262-cycle sequence.
- START pulsed again at cycle 50 of a run → ignored; DONE still occurs at cycle 262, and exactly one DONE pulse is seen.
- RN pulled low during RESIDUE of RESOLVE at bit 60 → all outputs at reset values asynchronously; after RN release, START gives a correct full result.
- NUM_EVAL=1, RST_CYC=SETTLE_CYC=EVAL_CYC=1 with random PUF data → DONE at 1+6+128=135 cycles, RESP equals the sampled data, UNSTABLE_CNT=0.

Source files
------------

// File: rtl/xor_puf_eval_ctrl_if.sv
// Handshake and pin bundle between the SPI register bank, the evaluation controller and the
// XOR PUF macro.
interface xor_puf_eval_ctrl_if #(
  parameter int unsigned N_BITS = 128
) ();
  logic              START;
  logic              ABORT;
  logic [N_BITS-1:0] PUF_OUT_XOR;
  logic              I1_XOR;
  logic              I2_XOR;
  logic              RESET_XOR;
  logic [N_BITS-1:0] RESP;
  logic [7:0]        UNSTABLE_CNT;
  logic              BUSY;
  logic              DONE;
  logic              VALID;

  // Controller side.
  modport slave (
    input  START, ABORT, PUF_OUT_XOR,
    output I1_XOR, I2_XOR, RESET_XOR, RESP, UNSTABLE_CNT, BUSY, DONE, VALID
  );

  // Register bank / PUF macro side.
  modport master (
    output START, ABORT, PUF_OUT_XOR,
    input  I1_XOR, I2_XOR, RESET_XOR, RESP, UNSTABLE_CNT, BUSY, DONE, VALID
  );
endinterface

// File: rtl/xor_puf_eval_ctrl.sv
// Sequencer for the XOR PUF macro: repeated reset/settle/excite/sample evaluations, per-bit
// ones counting, majority-voted response and unstable-bit count.
module xor_puf_eval_ctrl #(
  parameter int unsigned N_BITS     = 128,
  parameter int unsigned NUM_EVAL   = 7,
  parameter int unsigned RST_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned EVAL_CYC   = 8
) (
  input logic                CLK,
  input logic                RN,
  xor_puf_eval_ctrl_if.slave bus
);

  localparam int unsigned BitW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [7:0]      RstLast    = 8'(RST_CYC - 1);
  localparam logic [7:0]      SettleLast = 8'(SETTLE_CYC - 1);
  localparam logic [7:0]      EvalLast   = 8'(EVAL_CYC - 1);
  localparam logic [3:0]      NumEvalW   = 4'(NUM_EVAL);
  localparam logic [3:0]      MajThr     = 4'(NUM_EVAL / 2);
  localparam logic [BitW-1:0] BitLast    = BitW'(N_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRst,
    StSettle,
    StExcite,
    StSample,
    StAccum,
    StResolve,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cyc_q, cyc_d;
  logic [3:0]        eval_q, eval_d;
  logic [BitW-1:0]   bit_q, bit_d;

  logic              i1_q, i1_d;
  logic              rst_pin_q, rst_pin_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;

  logic [N_BITS-1:0] sync1_q, sync2_q;
  logic [3:0]        cnt_q [N_BITS];
  logic [N_BITS-1:0] resp_q;
  logic [7:0]        unst_q;

  logic              accept;
  logic              abort_run;
  logic [3:0]        cur_cnt;
  logic              cur_unstable;

  assign accept       = (state_q == StIdle) && bus.START && !bus.ABORT;
  assign abort_run    = (state_q != StIdle) && bus.ABORT;
  assign cur_cnt      = cnt_q[bit_q];
  assign cur_unstable = (cur_cnt != 4'd0) && (cur_cnt != NumEvalW);

  // Pin values are derived from the current state and registered, so every pin phase lags its
  // state by one cycle while keeping its length; an abort forces the pins idle on the same edge.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    eval_d    = eval_q;
    bit_d     = bit_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    i1_d      = 1'b0;
    rst_pin_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRst;
          cyc_d   = 8'd0;
          eval_d  = 4'd0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      StRst: begin
        if (cyc_q == RstLast) begin
          state_d = StSettle;
          cyc_d   = 8'd0;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      StSettle: begin
        rst_pin_d = 1'b1;
        if (cyc_q == SettleLast) begin
          state_d = StExcite;
          cyc_d   = 8'd0;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      StExcite: begin
        rst_pin_d = 1'b1;
        i1_d      = 1'b1;
        if (cyc_q == EvalLast) begin
          state_d = StSample;
          cyc_d   = 8'd0;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      StSample: begin
        rst_pin_d = 1'b1;
        i1_d      = 1'b1;
        if (cyc_q == 8'd1) begin
          state_d = StAccum;
          cyc_d   = 8'd0;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      StAccum: begin
        eval_d = eval_q + 4'd1;
        if (eval_d == NumEvalW) begin
          state_d = StResolve;
          bit_d   = '0;
        end else begin
          state_d = StRst;
          cyc_d   = 8'd0;
        end
      end
      StResolve: begin
        if (bit_q == BitLast) begin
          state_d = StFin;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      StFin: begin
        done_d  = 1'b1;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort_run) begin
      state_d   = StIdle;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      valid_d   = valid_q;
      i1_d      = 1'b0;
      rst_pin_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q   <= StIdle;
      cyc_q     <= 8'd0;
      eval_q    <= 4'd0;
      bit_q     <= '0;
      i1_q      <= 1'b0;
      rst_pin_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      eval_q    <= eval_d;
      bit_q     <= bit_d;
      i1_q      <= i1_d;
      rst_pin_q <= rst_pin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
    end
  end

  // Synchroniser runs every cycle; ACCUM adds the second stage into the per-bit counters.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync1_q <= '0;
      sync2_q <= '0;
      resp_q  <= '0;
      unst_q  <= 8'd0;
      for (int i = 0; i < int'(N_BITS); i++) begin
        cnt_q[i] <= 4'd0;
      end
    end else begin
      sync1_q <= bus.PUF_OUT_XOR;
      sync2_q <= sync1_q;

      if (accept) begin
        for (int i = 0; i < int'(N_BITS); i++) begin
          cnt_q[i] <= 4'd0;
        end
      end else if ((state_q == StAccum) && !abort_run) begin
        for (int i = 0; i < int'(N_BITS); i++) begin
          cnt_q[i] <= cnt_q[i] + {3'b000, sync2_q[i]};
        end
      end

      if ((state_q == StAccum) && (state_d == StResolve)) begin
        unst_q <= 8'd0;
      end else if ((state_q == StResolve) && !abort_run) begin
        resp_q[bit_q] <= (cur_cnt > MajThr);
        if (cur_unstable && (unst_q != 8'hFF)) begin
          unst_q <= unst_q + 8'd1;
        end
      end
    end
  end

  assign bus.I1_XOR       = i1_q;
  assign bus.I2_XOR       = i1_q;
  assign bus.RESET_XOR    = rst_pin_q;
  assign bus.RESP         = resp_q;
  assign bus.UNSTABLE_CNT = unst_q;
  assign bus.BUSY         = busy_q;
  assign bus.DONE         = done_q;
  assign bus.VALID        = valid_q;

endmodule

// File: tb/tb_xor_puf_eval_ctrl.sv
// Directed bench for xor_puf_eval_ctrl: default instance with a per-evaluation PUF model and a
// minimal-timing instance fed with constant random data.
module tb_xor_puf_eval_ctrl;

  logic CLK;
  logic RN;

  int n_assert = 0;
  int n_fail   = 0;

  int puf_mode = 0;
  int puf_e    = 0;

  logic [127:0] a5;
  logic [127:0] exp1;
  logic [127:0] rnd;

  xor_puf_eval_ctrl_if #(.N_BITS(128)) bus ();
  xor_puf_eval_ctrl_if #(.N_BITS(128)) bus2 ();

  xor_puf_eval_ctrl #(
    .N_BITS(128), .NUM_EVAL(7), .RST_CYC(4), .SETTLE_CYC(4), .EVAL_CYC(8)
  ) dut (
    .CLK(CLK),
    .RN (RN),
    .bus(bus)
  );

  xor_puf_eval_ctrl #(
    .N_BITS(128), .NUM_EVAL(1), .RST_CYC(1), .SETTLE_CYC(1), .EVAL_CYC(1)
  ) dut2 (
    .CLK(CLK),
    .RN (RN),
    .bus(bus2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [127:0] pat(input int mode, input int e);
    logic [127:0] v;
    v = {16{8'hA5}};
    if (mode == 1) begin
      v[0]   = (e == 0) || (e == 2) || (e == 4);
      v[127] = (e < 4);
    end
    return v;
  endfunction

  // PUF model: a new value per evaluation, presented when the excitation rises.
  always @(posedge bus.I1_XOR or posedge bus.START) begin
    if (bus.START) begin
      puf_e           = 0;
      bus.PUF_OUT_XOR = pat(0, 0);
    end else begin
      bus.PUF_OUT_XOR = pat(puf_mode, puf_e);
      puf_e           = puf_e + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit which, input int restart_at, input int abort_at,
                     output int done_at, output int n_done, output int i1_hi,
                     output int rs_hi, output int busy0, output logic [5:0] snap);
    done_at = -1;
    n_done  = 0;
    i1_hi   = 0;
    rs_hi   = 0;
    snap    = '0;
    if (which) bus2.START = 1'b1;
    else       bus.START  = 1'b1;
    @(posedge CLK); #1;
    bus.START  = 1'b0;
    bus2.START = 1'b0;
    busy0 = which ? int'(bus2.BUSY) : int'(bus.BUSY);
    for (int c = 1; c <= 280; c++) begin
      @(posedge CLK); #1;
      if (which ? bus2.I1_XOR : bus.I1_XOR) i1_hi++;
      if (which ? bus2.RESET_XOR : bus.RESET_XOR) rs_hi++;
      if (which ? bus2.DONE : bus.DONE) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (c == abort_at + 1) begin
        snap = {bus.BUSY, bus.RESET_XOR, bus.I1_XOR, bus.I2_XOR, bus.DONE, bus.VALID};
      end
      bus.START = (c == restart_at) && !which;
      bus.ABORT = (c == abort_at);
    end
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
  endtask

  int         done_at, n_done, i1_hi, rs_hi, busy0;
  logic [5:0] snap;

  initial begin
    a5   = {16{8'hA5}};
    exp1 = a5;
    exp1[0]   = 1'b0;
    exp1[127] = 1'b1;
    rnd  = {$urandom, $urandom, $urandom, $urandom};

    RN         = 1'b0;
    bus.START  = 1'b0;
    bus.ABORT  = 1'b0;
    bus2.START = 1'b0;
    bus2.ABORT = 1'b0;
    bus2.PUF_OUT_XOR = rnd;
    #3;
    check("rst_resp", bus.RESP, '0);
    check("rst_unst", 128'(bus.UNSTABLE_CNT), 128'd0);
    check("rst_flags", 128'({bus.BUSY, bus.DONE, bus.VALID}), 128'd0);
    check("rst_pins", 128'({bus.RESET_XOR, bus.I1_XOR, bus.I2_XOR}), 128'd0);
    #9 RN = 1'b1;
    @(posedge CLK); #1;

    // Constant A5 pattern.
    puf_mode = 0;
    run(1'b0, -1, -1, done_at, n_done, i1_hi, rs_hi, busy0, snap);
    check("a5_busy0", 128'(busy0), 128'd1);
    check("a5_done_at", 128'(done_at), 128'd262);
    check("a5_n_done", 128'(n_done), 128'd1);
    check("a5_i1_hi", 128'(i1_hi), 128'd70);
    check("a5_rs_hi", 128'(rs_hi), 128'd98);
    check("a5_resp", bus.RESP, a5);
    check("a5_unst", 128'(bus.UNSTABLE_CNT), 128'd0);
    check("a5_valid", 128'(bus.VALID), 128'd1);
    check("a5_busy_end", 128'(bus.BUSY), 128'd0);

    // Bit 0 high in 3/7 evaluations, bit 127 high in 4/7.
    puf_mode = 1;
    run(1'b0, -1, -1, done_at, n_done, i1_hi, rs_hi, busy0, snap);
    check("maj_done_at", 128'(done_at), 128'd262);
    check("maj_resp0", 128'(bus.RESP[0]), 128'd0);
    check("maj_resp127", 128'(bus.RESP[127]), 128'd1);
    check("maj_resp", bus.RESP, exp1);
    check("maj_unst", 128'(bus.UNSTABLE_CNT), 128'd2);
    puf_mode = 0;

    // Abort during the third excitation window.
    run(1'b0, -1, 48, done_at, n_done, i1_hi, rs_hi, busy0, snap);
    check("abort_snap", 128'(snap), 128'd0);
    check("abort_n_done", 128'(n_done), 128'd0);
    check("abort_valid", 128'(bus.VALID), 128'd0);
    run(1'b0, -1, -1, done_at, n_done, i1_hi, rs_hi, busy0, snap);
    check("post_abort_done_at", 128'(done_at), 128'd262);
    check("post_abort_resp", bus.RESP, a5);
    check("post_abort_valid", 128'(bus.VALID), 128'd1);

    // Second START while busy.
    run(1'b0, 50, -1, done_at, n_done, i1_hi, rs_hi, busy0, snap);
    check("restart_done_at", 128'(done_at), 128'd262);
    check("restart_n_done", 128'(n_done), 128'd1);

    // Reset during RESOLVE, bit 60.
    bus.START = 1'b1;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    repeat (193) @(posedge CLK);
    #2 RN = 1'b0;
    #1;
    check("rn_resp", bus.RESP, '0);
    check("rn_unst", 128'(bus.UNSTABLE_CNT), 128'd0);
    check("rn_flags", 128'({bus.BUSY, bus.DONE, bus.VALID}), 128'd0);
    check("rn_pins", 128'({bus.RESET_XOR, bus.I1_XOR, bus.I2_XOR}), 128'd0);
    #3 RN = 1'b1;
    @(posedge CLK); #1;
    run(1'b0, -1, -1, done_at, n_done, i1_hi, rs_hi, busy0, snap);
    check("post_rn_done_at", 128'(done_at), 128'd262);
    check("post_rn_resp", bus.RESP, a5);
    check("post_rn_valid", 128'(bus.VALID), 128'd1);

    // Minimal timing instance.
    run(1'b1, -1, -1, done_at, n_done, i1_hi, rs_hi, busy0, snap);
    check("min_busy0", 128'(busy0), 128'd1);
    check("min_done_at", 128'(done_at), 128'd135);
    check("min_n_done", 128'(n_done), 128'd1);
    check("min_resp", bus2.RESP, rnd);
    check("min_unst", 128'(bus2.UNSTABLE_CNT), 128'd0);
    check("min_valid", 128'(bus2.VALID), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
